// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package serial_cmp_pkg;

  localparam int CMP_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cmp_state_e;

  // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_mag_cmp_eq1.sv
// Single-bit equality cell used by the serial comparator datapath.
module eq1_cell (
  input  logic x,
  input  logic y,
  output logic equal
);

  assign equal = ~(x ^ y);

endmodule

// File: rtl/serial_mag_cmp.sv
// Serial unsigned magnitude comparator: walks a/b MSB first, one bit pair
// per clock, and reports eq/gr after W shift cycles.
module serial_mag_cmp
  import serial_cmp_pkg::*;
#(
  parameter int W = CMP_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         eq,
  output logic         gr
);

  localparam int CW = cnt_width(W);

  cmp_state_e      state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            diff_q, diff_d;
  logic            gt_q, gt_d;
  logic            eq_q, eq_d;
  logic            gr_q, gr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            bit_eq_s;

  eq1_cell u_eq1 (
    .x     (a_q[W-1]),
    .y     (b_q[W-1]),
    .equal (bit_eq_s)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      cnt_q   <= {CW{1'b0}};
      diff_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      gr_q    <= gr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
        else       state_d = IDLE;
      end
      SHIFT: begin
        if (cnt_q == {CW{1'b0}}) state_d = DONE;
        else                     state_d = SHIFT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, MSB-first scan, result capture.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    gt_d   = gt_q;
    eq_d   = eq_q;
    gr_d   = gr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          cnt_d  = CW'(W - 1);
          diff_d = 1'b0;
          gt_d   = 1'b0;
        end else begin
          a_d = a_q;
        end
      end
      SHIFT: begin
        // Only the first differing bit pair decides the ordering.
        if (!diff_q && !bit_eq_s) begin
          diff_d = 1'b1;
          gt_d   = a_q[W-1];
        end else begin
          diff_d = diff_q;
        end
        a_d   = a_q << 1'b1;
        b_d   = b_q << 1'b1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == {CW{1'b0}}) begin
          eq_d = ~diff_d;
          gr_d = gt_d;
        end else begin
          eq_d = eq_q;
        end
      end
      default: begin
        a_d = a_q;
      end
    endcase
  end

  // Moore outputs, registered from the next state.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign gr   = gr_q;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Self-checking bench for serial_mag_cmp: directed vector table, random
// operands against an arithmetic model, and multi-cycle corner sequences.
module tb_serial_mag_cmp;

  localparam int W = 8;
  localparam int P = W + 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start8 = 1'b0;
  logic [W-1:0] a8 = '0, b8 = '0;
  logic         busy8, done8, eq8, gr8;
  logic         start1 = 1'b0;
  logic [0:0]   a1 = '0, b1 = '0;
  logic         busy1, done1, eq1, gr1;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic prev_eq = 1'b0, prev_gr = 1'b0;

  serial_mag_cmp #(.W(W)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .eq(eq8), .gr(gr8)
  );

  serial_mag_cmp #(.W(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .eq(eq1), .gr(gr1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         eq;
    logic         gr;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One full comparison on the W=8 instance, checking latency, busy, hold and result.
  task automatic run_cmp(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic exp_eq, input logic exp_gr);
    int n;
    a8 = av; b8 = bv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < W + 4) begin
      chk("busy_in_shift", busy8, 1);
      chk("eq_hold", eq8, prev_eq);
      chk("gr_hold", gr8, prev_gr);
      a8 = W'($urandom); b8 = W'($urandom);
      tick();
      n++;
    end
    chk("latency", n, W);
    chk("busy_in_done", busy8, 1);
    chk("eq", eq8, exp_eq);
    chk("gr", gr8, exp_gr);
    chk("not_both", eq8 & gr8, 0);
    prev_eq = exp_eq; prev_gr = exp_gr;
    tick();
    chk("done_one_cycle", done8, 0);
    chk("busy_idle", busy8, 0);
    chk("eq_after", eq8, exp_eq);
    chk("gr_after", gr8, exp_gr);
  endtask

  initial begin
    logic [W-1:0] av, bv;
    logic [W-1:0] hv_a[3*P];
    logic [W-1:0] hv_b[3*P];
    int j;

    vecs[0] = '{8'hA5, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h80, 8'h7F, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'h01, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h7F, 8'h80, 1'b0, 1'b0};

    // Reset state
    reset_n = 1'b0;
    tick(); tick();
    chk("rst_busy", busy8, 0); chk("rst_done", done8, 0);
    chk("rst_eq", eq8, 0);     chk("rst_gr", gr8, 0);
    chk("rst_busy1", busy1, 0); chk("rst_done1", done1, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_no_start", busy8, 0);

    for (int i = 0; i < 6; i++) run_cmp(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].gr);

    // Random operands against arithmetic reference
    for (int i = 0; i < 30; i++) begin
      av = W'($urandom);
      bv = ($urandom_range(0, 3) == 0) ? av : W'($urandom);
      run_cmp(av, bv, av == bv, av > bv);
      repeat ($urandom_range(0, 2)) tick();
    end

    // start held high with fresh operands every cycle
    start8 = 1'b1;
    for (int i = 0; i < 3 * P; i++) begin
      hv_a[i] = W'($urandom);
      hv_b[i] = ($urandom_range(0, 2) == 0) ? hv_a[i] : W'($urandom);
      a8 = hv_a[i]; b8 = hv_b[i];
      tick();
      j = i - (i % P);
      chk("held_done", done8, (i % P) == W);
      chk("held_busy", busy8, (i % P) != P - 1);
      if ((i % P) == W) begin
        chk("held_eq", eq8, hv_a[j] == hv_b[j]);
        chk("held_gr", gr8, hv_a[j] > hv_b[j]);
        prev_eq = (hv_a[j] == hv_b[j]);
        prev_gr = (hv_a[j] > hv_b[j]);
      end
    end
    start8 = 1'b0;
    tick();

    // Make the held results nonzero, then reset in the middle of SHIFT
    run_cmp(8'h90, 8'h10, 1'b0, 1'b1);
    a8 = 8'h33; b8 = 8'h22; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    chk("pre_rst_busy", busy8, 1);
    reset_n = 1'b0; start8 = 1'b1;
    tick();
    reset_n = 1'b1; start8 = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_eq", eq8, 0);
    chk("abort_gr", gr8, 0);
    chk("abort_done", done8, 0);
    prev_eq = 1'b0; prev_gr = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      chk("no_done_after_abort", done8, 0);
    end
    run_cmp(8'h3C, 8'h3D, 1'b0, 1'b0);

    // W=1 instance, all operand pairs
    for (int i = 0; i < 4; i++) begin
      a1 = 1'(i >> 1); b1 = 1'(i);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("w1_busy", busy1, 1);
      chk("w1_done_early", done1, 0);
      tick();
      chk("w1_done", done1, 1);
      chk("w1_eq", eq1, (i >> 1) == (i & 1));
      chk("w1_gr", gr1, (i >> 1) > (i & 1));
      tick();
      chk("w1_done_pulse", done1, 0);
      chk("w1_idle", busy1, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_mag_cmp.md
SERIAL_MAG_CMP -- requirements
Module: serial_mag_cmp

Interface
REQ-001 Parameter W SHALL be: W, default 8, operand width in bits (legal range 1..32).
REQ-002 Port clk SHALL be: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port reset_n SHALL be: reset_n  input  1  synchronous, active-low reset.
REQ-004 Port start SHALL be: start  input  1  request to compare a and b; sampled only in IDLE.
REQ-005 Port a SHALL be: a  input  W  first operand, unsigned.
REQ-006 Port b SHALL be: b  input  W  second operand, unsigned.
REQ-007 Port busy SHALL be: busy  output  1  high while a comparison is in progress (SHIFT or DONE).
REQ-008 Port done SHALL be: done  output  1  one-cycle pulse; eq/gr valid from this cycle.
REQ-009 Port eq SHALL be: eq  output  1  registered result, a == b.
REQ-010 Port gr SHALL be: gr  output  1  registered result, a > b (unsigned).

Function
REQ-011 Block SHALL compare operands serially, MSB first, one bit pair per clock through a 1-bit equality cell.
REQ-012 FSM SHALL have states IDLE, SHIFT, DONE; Moore outputs.
REQ-013 IDLE: start=1 at an edge SHALL latch a, b into shift registers, load bit counter with W-1, clear internal diff/gt flags, and go to SHIFT.
REQ-014 IDLE with start=0 SHALL remain IDLE; no register other than outputs' hold changes.
REQ-015 SHIFT: each edge SHALL evaluate a_reg[W-1] vs b_reg[W-1], then shift both registers left one bit and decrement the counter.
REQ-016 SHIFT: on the first unequal bit pair (diff flag clear), diff SHALL set and gt SHALL take a's bit value; later bit pairs SHALL NOT change diff or gt.
REQ-017 SHIFT SHALL last exactly W cycles (counter 0 processed, then go to DONE); no early termination.
REQ-018 On the SHIFT->DONE edge, eq SHALL load ~diff_final and gr SHALL load gt_final, including the last bit's contribution.
REQ-019 DONE SHALL assert done for exactly one cycle and return to IDLE on the next edge.
REQ-020 Latency: start sampled at edge k SHALL give done=1 during the cycle after edge k+W (W+1 clocks start-to-done).
REQ-021 start during SHIFT or DONE SHALL be ignored (not queued); operands a/b SHALL NOT be resampled mid-comparison.
REQ-022 eq and gr SHALL hold their values from done until the DONE entry of the next comparison; never both 1.
REQ-023 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-024 W=1 SHALL work: one SHIFT cycle, done two clocks after start.

Reset
REQ-025 reset_n=0 at an edge SHALL force IDLE, busy=0, done=0, eq=0, gr=0, clear shift registers, counter, diff, gt.
REQ-026 reset_n=0 mid-SHIFT or in DONE SHALL abort the comparison with no done pulse; reset takes priority over start.

Structure
REQ-027 Package serial_cmp_pkg SHALL hold the state typedef (IDLE, SHIFT, DONE) and the default-width constant CMP_W_DEFAULT=8.
REQ-028 The per-bit equality SHALL be one instantiated sub-module eq1_cell (inputs two bits, output equal); counter width SHALL be $clog2(W) with minimum 1.

Verification
REQ-029 W=8, a=0xA5, b=0xA5, start pulse -> done high 9 clocks later, eq=1, gr=0, busy high for 9 cycles.
REQ-030 a=0x80, b=0x7F -> eq=0, gr=1 (MSB decides; later bits ignored).
REQ-031 a=0x00, b=0xFF -> eq=0, gr=0; a=0x01, b=0x00 -> eq=0, gr=1 (LSB decides).
REQ-032 start held high continuously with new a/b each cycle -> operands resampled only in IDLE, one done per W+2 clocks, results match operands at acceptance.
REQ-033 reset_n low for one edge at SHIFT cycle 4 -> next cycle busy=0, eq=0, gr=0, no done pulse; subsequent start runs a clean comparison.
REQ-034 W=1 instance, a=1, b=0 -> done two clocks after start, gr=1, eq=0.
